// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the execute-stage branch unit:
//   - Funct3 encodings of the conditional branch compares
//   - the control half of the ID/EX pipeline register
//   - the default trap vector used for misaligned control-flow targets
// ---------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

    // Control fields of one instruction held in E.
    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [2:0] funct3;
    } idex_ctrl_t;

    // A bubble only needs valid cleared; the remaining fields are zeroed
    // so a bubble can never look like a branch or jump.
    localparam idex_ctrl_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
// Combinational conditional-branch compare.
// Ports:
//   a_i      in  W  rs1 operand
//   b_i      in  W  rs2 operand
//   funct3_i in  3  compare type (EQ/NE/LT/GE/LTU/GEU)
//   taken_o  out 1  condition holds; 010/011 are never taken
// ---------------------------------------------------------------------------
module branch_cmp
    import branch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   funct3_i,
    output logic         taken_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a_i == b_i);
    assign lt_s = ($signed(a_i) < $signed(b_i));
    assign lt_u = (a_i < b_i);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = eq;
            F3_BNE:  taken_o = ~eq;
            F3_BLT:  taken_o = lt_s;
            F3_BGE:  taken_o = ~lt_s;
            F3_BLTU: taken_o = lt_u;
            F3_BGEU: taken_o = ~lt_u;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_execute_stage.sv
// ---------------------------------------------------------------------------
// branch_execute_stage
// Execute-stage control-flow unit. Holds the ID/EX register for branch and
// jump fields, resolves BEQ..BGEU, JAL and JALR, and drives the fetch
// redirect (PCSrcE/PCTargetE) plus the IF/ID flush. Misaligned targets are
// redirected to TRAP_VEC. Counts retired branches and taken control flow.
// Ports:
//   clk          in   1     rising-edge clock
//   rst          in   1     synchronous reset, active-low
//   StallE       in   1     hold the ID/EX register
//   ValidD       in   1     decode slot holds a real instruction
//   BranchD      in   1     conditional branch
//   JumpD        in   1     JAL or JALR
//   JalrD        in   1     register-relative target
//   Funct3D      in   3     branch compare type
//   RD1D/RD2D    in   XLEN  rs1/rs2 values
//   ImmExtD      in   XLEN  sign-extended immediate
//   PCD          in   XLEN  decode PC
//   PCPlus4D     in   XLEN  decode PC+4
//   PCSrcE       out  1     redirect fetch
//   PCTargetE    out  XLEN  redirect address (0 when E is a bubble)
//   FlushD       out  1     squash IF/ID
//   PCPlus4E     out  XLEN  link value
//   MisalignE    out  1     misaligned-target trap
//   BranchCount  out  32    retired conditional branches
//   TakenCount   out  32    retired taken branches plus jumps
// ---------------------------------------------------------------------------
module branch_execute_stage
    import branch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallE,
    input  logic            ValidD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic            JalrD,
    input  logic [2:0]      Funct3D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            FlushD,
    output logic [XLEN-1:0] PCPlus4E,
    output logic            MisalignE,
    output logic [31:0]     BranchCount,
    output logic [31:0]     TakenCount
);

    // ID/EX register
    idex_ctrl_t      ctrl_q;
    idex_ctrl_t      ctrl_d;
    logic [XLEN-1:0] rd1_q;
    logic [XLEN-1:0] rd2_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pcplus4_q;

    // Event counters
    logic [31:0] branch_cnt_q;
    logic [31:0] branch_cnt_d;
    logic [31:0] taken_cnt_q;
    logic [31:0] taken_cnt_d;

    // Resolution signals
    logic            cond_taken;
    logic            take_e;
    logic            retire_e;
    logic [XLEN-1:0] target_base;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] raw_target;
    logic            misalign_e;

    branch_cmp #(
        .W (XLEN)
    ) u_cmp (
        .a_i      (rd1_q),
        .b_i      (rd2_q),
        .funct3_i (ctrl_q.funct3),
        .taken_o  (cond_taken)
    );

    // One adder serves both JAL/branches (PC-relative) and JALR.
    assign target_base = ctrl_q.jalr ? rd1_q : pc_q;
    assign target_sum  = target_base + imm_q;
    // JALR clears bit 0 of the sum; PC-relative targets keep it as computed.
    assign raw_target  = {target_sum[XLEN-1:1], target_sum[0] & ~ctrl_q.jalr};

    assign take_e     = ctrl_q.valid & (ctrl_q.jump | (ctrl_q.branch & cond_taken));
    // Without compressed instructions any target with bit 1 set is misaligned.
    assign misalign_e = take_e & raw_target[1];
    assign retire_e   = ctrl_q.valid & ~StallE;

    // Next state of the control fields: hold on stall, bubble behind a
    // redirect, otherwise accept the decode slot.
    always_comb begin
        ctrl_d = ctrl_q;
        if (!StallE) begin
            if (take_e) begin
                ctrl_d = IDEX_BUBBLE;
            end else begin
                ctrl_d.valid  = ValidD;
                ctrl_d.branch = BranchD;
                ctrl_d.jump   = JumpD;
                ctrl_d.jalr   = JalrD;
                ctrl_d.funct3 = Funct3D;
            end
        end
    end

    // Counters advance only when the E instruction leaves E, so a stalled
    // instruction is counted once.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (retire_e) begin
            branch_cnt_d = branch_cnt_q + {31'd0, ctrl_q.branch};
            taken_cnt_d  = taken_cnt_q + {31'd0, take_e};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q       <= IDEX_BUBBLE;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            pcplus4_q    <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            // Datapath fields are don't-care in a bubble, so they simply
            // follow decode whenever E is not stalled.
            if (!StallE) begin
                rd1_q     <= RD1D;
                rd2_q     <= RD2D;
                imm_q     <= ImmExtD;
                pc_q      <= PCD;
                pcplus4_q <= PCPlus4D;
            end
        end
    end

    assign PCSrcE      = take_e;
    assign FlushD      = take_e;
    assign MisalignE   = misalign_e;
    assign PCTargetE   = !ctrl_q.valid ? '0 : (misalign_e ? TRAP_VEC : raw_target);
    assign PCPlus4E    = pcplus4_q;
    assign BranchCount = branch_cnt_q;
    assign TakenCount  = taken_cnt_q;

endmodule

// File: tb/tb_branch_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_branch_execute_stage
// Hand-written corner sequences, a table of single-instruction vectors, and
// a randomized run checked against a behavioural model of the E stage.
// ---------------------------------------------------------------------------
module tb_branch_execute_stage;

    logic        clk;
    logic        rst;
    logic        StallE;
    logic        ValidD;
    logic        BranchD;
    logic        JumpD;
    logic        JalrD;
    logic [2:0]  Funct3D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ImmExtD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        FlushD;
    logic [31:0] PCPlus4E;
    logic        MisalignE;
    logic [31:0] BranchCount;
    logic [31:0] TakenCount;

    int total = 0;
    int bad   = 0;

    branch_execute_stage dut (
        .clk         (clk),
        .rst         (rst),
        .StallE      (StallE),
        .ValidD      (ValidD),
        .BranchD     (BranchD),
        .JumpD       (JumpD),
        .JalrD       (JalrD),
        .Funct3D     (Funct3D),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .ImmExtD     (ImmExtD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .FlushD      (FlushD),
        .PCPlus4E    (PCPlus4E),
        .MisalignE   (MisalignE),
        .BranchCount (BranchCount),
        .TakenCount  (TakenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid;
        logic        br;
        logic        jp;
        logic        jr;
        logic [2:0]  f3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
    } mrec_t;

    mrec_t       m_e;
    logic [31:0] m_bc;
    logic [31:0] m_tc;

    function automatic logic m_cond(input mrec_t e);
        case (e.f3)
            3'd0:    return e.rd1 == e.rd2;
            3'd1:    return e.rd1 != e.rd2;
            3'd4:    return $signed(e.rd1) <  $signed(e.rd2);
            3'd5:    return $signed(e.rd1) >= $signed(e.rd2);
            3'd6:    return e.rd1 <  e.rd2;
            3'd7:    return e.rd1 >= e.rd2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_take(input mrec_t e);
        return e.valid && (e.jp || (e.br && m_cond(e)));
    endfunction

    function automatic logic [31:0] m_raw(input mrec_t e);
        if (e.jr) return (e.rd1 + e.imm) & 32'hFFFF_FFFE;
        return e.pc + e.imm;
    endfunction

    function automatic logic m_mis(input mrec_t e);
        logic [31:0] r;
        r = m_raw(e);
        return m_take(e) && (r[1] == 1'b1);
    endfunction

    function automatic logic [31:0] m_target(input mrec_t e);
        if (!e.valid) return 32'h0;
        if (m_mis(e)) return 32'h0000_0100;
        return m_raw(e);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_e  <= '0;
            m_bc <= 32'd0;
            m_tc <= 32'd0;
        end else if (!StallE) begin
            if (m_e.valid) begin
                m_bc <= m_bc + 32'(m_e.br);
                m_tc <= m_tc + 32'(m_take(m_e));
            end
            if (m_take(m_e)) m_e <= '0;
            else m_e <= {ValidD, BranchD, JumpD, JalrD, Funct3D,
                         RD1D, RD2D, ImmExtD, PCD, PCPlus4D};
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        mrec_t e;
        e = m_e;
        chk("m_pcsrc",    32'(PCSrcE),    32'(m_take(e)));
        chk("m_flush",    32'(FlushD),    32'(m_take(e)));
        chk("m_target",   PCTargetE,      m_target(e));
        chk("m_misalign", 32'(MisalignE), 32'(m_mis(e)));
        chk("m_bcount",   BranchCount,    m_bc);
        chk("m_tcount",   TakenCount,     m_tc);
        if (e.valid) chk("m_pcplus4", PCPlus4E, e.pc4);
    endtask

    task automatic drive(input logic v, input logic br, input logic jp, input logic jr,
                         input logic [2:0] f3, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc);
        ValidD   = v;
        BranchD  = br;
        JumpD    = jp;
        JalrD    = jr;
        Funct3D  = f3;
        RD1D     = rd1;
        RD2D     = rd2;
        ImmExtD  = imm;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic        br;
        logic        jp;
        logic        jr;
        logic [2:0]  f3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        e_take;
        logic [31:0] e_tgt;
        logic        e_mis;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            v  br jp jr f3    rd1           rd2        imm           pc           take tgt           mis
        vecs[0]  = '{1, 1, 0, 0, 3'd0, 32'd5,        32'd6,     32'h20,       32'h40,      0, 32'h60,       0};
        vecs[1]  = '{1, 1, 0, 0, 3'd1, 32'd5,        32'd6,     32'h20,       32'h40,      1, 32'h60,       0};
        vecs[2]  = '{1, 1, 0, 0, 3'd4, 32'hFFFFFFF0, 32'd3,     32'hFFFFFFF0, 32'h200,     1, 32'h1F0,      0};
        vecs[3]  = '{1, 1, 0, 0, 3'd5, 32'hFFFFFFF0, 32'd3,     32'hFFFFFFF0, 32'h200,     0, 32'h1F0,      0};
        vecs[4]  = '{1, 1, 0, 0, 3'd7, 32'hFFFFFFF0, 32'd3,     32'h8,        32'h200,     1, 32'h208,      0};
        vecs[5]  = '{1, 1, 0, 0, 3'd2, 32'd7,        32'd7,     32'h8,        32'h300,     0, 32'h308,      0};
        vecs[6]  = '{1, 1, 0, 0, 3'd3, 32'd7,        32'd7,     32'h8,        32'h300,     0, 32'h308,      0};
        vecs[7]  = '{1, 0, 1, 0, 3'd0, 32'd0,        32'd0,     32'h6,        32'h100,     1, 32'h100,      1};
        vecs[8]  = '{1, 1, 0, 0, 3'd0, 32'd1,        32'd2,     32'h6,        32'h100,     0, 32'h106,      0};
        vecs[9]  = '{1, 0, 1, 1, 3'd0, 32'h2001,     32'd0,     32'h3,        32'h400,     1, 32'h2004,     0};
        vecs[10] = '{1, 0, 1, 1, 3'd0, 32'h2000,     32'd0,     32'h1,        32'h400,     1, 32'h2000,     0};
        vecs[11] = '{0, 0, 1, 0, 3'd0, 32'd0,        32'd0,     32'h40,       32'h500,     0, 32'h0,        0};
        vecs[12] = '{1, 1, 0, 0, 3'd7, 32'd9,        32'd9,     32'hC,        32'h600,     1, 32'h60C,      0};
        vecs[13] = '{1, 1, 0, 0, 3'd6, 32'd9,        32'd9,     32'hC,        32'h600,     0, 32'h60C,      0};

        // ---- reset held with a valid instruction in decode ----
        rst    = 1'b0;
        StallE = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1, 32'd2, 32'd3, 32'h80);
        repeat (3) tick();
        chk("rst_pcsrc",   32'(PCSrcE),    32'd0);
        chk("rst_target",  PCTargetE,      32'd0);
        chk("rst_flush",   32'(FlushD),    32'd0);
        chk("rst_mis",     32'(MisalignE), 32'd0);
        chk("rst_pcplus4", PCPlus4E,       32'd0);
        chk("rst_bcount",  BranchCount,    32'd0);
        chk("rst_tcount",  TakenCount,     32'd0);
        $display("reset: pcsrc=%0b target=%h counts=%0d/%0d", PCSrcE, PCTargetE, BranchCount, TakenCount);
        rst = 1'b1;
        tick();
        chk("release_pcplus4", PCPlus4E, 32'h84);
        chk("release_pcsrc", 32'(PCSrcE), 32'd0);
        $display("release: first instruction in E, link=%h", PCPlus4E);

        // ---- BEQ taken ----
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h20, 32'h40);
        tick();
        chk("beq_pcsrc",  32'(PCSrcE), 32'd1);
        chk("beq_target", PCTargetE,   32'h60);
        chk("beq_flush",  32'(FlushD), 32'd1);
        idle();
        tick();
        chk("beq_bubble", 32'(PCSrcE), 32'd0);
        chk("beq_bubble_target", PCTargetE, 32'd0);
        chk("beq_bcount", BranchCount, 32'd1);
        chk("beq_tcount", TakenCount,  32'd1);
        $display("beq: target=0x60 counts=%0d/%0d", BranchCount, TakenCount);

        // ---- BLTU vs BLT ----
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40);
        tick();
        chk("bltu_pcsrc",  32'(PCSrcE), 32'd0);
        chk("bltu_target", PCTargetE,   32'h50);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40);
        tick();
        chk("blt_pcsrc",   32'(PCSrcE), 32'd1);
        chk("bltu_bcount", BranchCount, 32'd2);
        chk("bltu_tcount", TakenCount,  32'd1);
        idle();
        tick();
        chk("blt_bcount", BranchCount, 32'd3);
        chk("blt_tcount", TakenCount,  32'd2);
        $display("bltu/blt: counts=%0d/%0d", BranchCount, TakenCount);

        // ---- JALR misaligned ----
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h1003, 32'd0, 32'h4, 32'h700);
        tick();
        chk("jalr_pcsrc",   32'(PCSrcE),    32'd1);
        chk("jalr_mis",     32'(MisalignE), 32'd1);
        chk("jalr_target",  PCTargetE,      32'h100);
        chk("jalr_pcplus4", PCPlus4E,       32'h704);
        idle();
        tick();
        chk("jalr_mis_once", 32'(MisalignE), 32'd0);
        chk("jalr_tcount",   TakenCount,     32'd3);
        $display("jalr: trap target, counts=%0d/%0d", BranchCount, TakenCount);

        // ---- stall during taken JAL ----
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h10);
        tick();
        chk("stall_pcsrc0",  32'(PCSrcE), 32'd1);
        chk("stall_target0", PCTargetE,   32'h8);
        StallE = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd1, 32'd1, 32'h40, 32'h900);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pcsrc",  32'(PCSrcE), 32'd1);
            chk("stall_flush",  32'(FlushD), 32'd1);
            chk("stall_target", PCTargetE,   32'h8);
            chk("stall_tcount", TakenCount,  32'd3);
            $display("stall cycle %0d: pcsrc=%0b target=%h taken=%0d", i, PCSrcE, PCTargetE, TakenCount);
        end
        StallE = 1'b0;
        tick();
        chk("unstall_pcsrc",  32'(PCSrcE), 32'd0);
        chk("unstall_tcount", TakenCount,  32'd4);
        chk("unstall_bcount", BranchCount, 32'd3);
        $display("unstall: bubble in E, taken=%0d", TakenCount);

        // ---- address wrap plus back-to-back JAL ----
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h10, 32'hFFFF_FFF8);
        tick();
        chk("wrap_pcsrc",  32'(PCSrcE), 32'd1);
        chk("wrap_target", PCTargetE,   32'h8);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h40, 32'h100);
        tick();
        chk("b2b_pcsrc",  32'(PCSrcE), 32'd0);
        chk("b2b_target", PCTargetE,   32'd0);
        chk("b2b_tcount", TakenCount,  32'd5);
        idle();
        tick();
        chk("b2b_tcount2", TakenCount, 32'd5);
        $display("wrap/back-to-back: second jump squashed, taken=%0d", TakenCount);

        // ---- reset during a stalled redirect ----
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h20, 32'h20);
        tick();
        chk("rstmid_pcsrc0", 32'(PCSrcE), 32'd1);
        rst    = 1'b0;
        StallE = 1'b1;
        tick();
        chk("rstmid_pcsrc",  32'(PCSrcE), 32'd0);
        chk("rstmid_target", PCTargetE,   32'd0);
        chk("rstmid_tcount", TakenCount,  32'd0);
        $display("reset mid-redirect: pcsrc=%0b taken=%0d", PCSrcE, TakenCount);
        rst    = 1'b1;
        StallE = 1'b0;
        idle();
        tick();

        // ---- vector table ----
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].br, vecs[i].jp, vecs[i].jr, vecs[i].f3,
                  vecs[i].rd1, vecs[i].rd2, vecs[i].imm, vecs[i].pc);
            tick();
            chk("vec_pcsrc",  32'(PCSrcE),    32'(vecs[i].e_take));
            chk("vec_flush",  32'(FlushD),    32'(vecs[i].e_take));
            chk("vec_target", PCTargetE,      vecs[i].e_tgt);
            chk("vec_mis",    32'(MisalignE), 32'(vecs[i].e_mis));
            check_model();
            $display("vec %0d: take=%0b target=%h mis=%0b", i, PCSrcE, PCTargetE, MisalignE);
            idle();
            tick();
            check_model();
        end

        // ---- randomized run against the model ----
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ops [5];
            int          kind;
            ops[0] = 32'd0;
            ops[1] = 32'd1;
            ops[2] = 32'hFFFF_FFFF;
            ops[3] = 32'h8000_0000;
            ops[4] = 32'h7FFF_FFFF;
            rst    = ($urandom_range(0, 49) != 0);
            StallE = ($urandom_range(0, 3) == 0);
            kind   = int'($urandom_range(0, 3));
            drive($urandom_range(0, 4) != 0,
                  (kind == 1) || (kind == 2),
                  kind == 3,
                  (kind == 3) && ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)),
                  ops[$urandom_range(0, 4)],
                  ops[$urandom_range(0, 4)],
                  $urandom & 32'hFFFF_FFFE,
                  $urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 3) == 0) RD1D = $urandom;
            tick();
            check_model();
            $display("rand %0d: rst=%0b stall=%0b take=%0b target=%h counts=%0d/%0d",
                     n, rst, StallE, PCSrcE, PCTargetE, BranchCount, TakenCount);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
